// File: rtl/ecc_decoder_pkg.sv
// Shared types, constants and the error locator for the packet ECC check/correct path.
package ecc_pkg;

   localparam int ECC_WORDS  = 8;
   localparam int ECC_WORD_W = 16;

   // Hamming column masks over data bits 14:0; bit k of (i+1) selects bit i.
   localparam logic [14:0] ECC_COL_MASK [0:3] = '{15'h5555, 15'h6666, 15'h7878, 15'h7F80};

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DECODE,
      OUT
   } ecc_dec_state_t;

   typedef enum logic [1:0] {
      LOC_CLEAN,
      LOC_CORR,
      LOC_UNCORR
   } ecc_kind_t;

   typedef struct packed {
      ecc_kind_t  kind;
      logic [2:0] word_idx;
      logic [3:0] bit_idx;
   } ecc_loc_t;

   // Maps the final syndrome onto the data bit to repair. The check byte is
   // trusted, so a nonzero syndrome together with s7 cannot be a single data error.
   function automatic ecc_loc_t ecc_locate(input logic [6:0] s, input logic s7);
      ecc_loc_t loc;
      loc.kind     = LOC_CLEAN;
      loc.word_idx = 3'd0;
      loc.bit_idx  = 4'd0;
      if (s == 7'd0) begin
         if (s7) begin
            // only word7[15] is outside the 7-bit code; s7 alone points at it
            loc.kind     = LOC_CORR;
            loc.word_idx = 3'd7;
            loc.bit_idx  = 4'd15;
         end
      end else if (s7) begin
         loc.kind = LOC_UNCORR;
      end else if (s[3:0] != 4'd0) begin
         loc.kind     = LOC_CORR;
         loc.word_idx = s[6:4];
         loc.bit_idx  = s[3:0] - 4'd1;
      end else begin
         // column 0 means a bit-15 error; bit 15 of word j is coded with row j+1
         loc.kind     = LOC_CORR;
         loc.word_idx = s[6:4] - 3'd1;
         loc.bit_idx  = 4'd15;
      end
      return loc;
   endfunction

endpackage

// File: rtl/ecc_decoder_if.sv
// Input beat stream, check byte and corrected output stream of the ECC decoder.
interface ecc_decoder_if;

   logic [7:0]                     code_in;
   logic                           in_valid;
   logic                           in_ready;
   logic [ecc_pkg::ECC_WORD_W-1:0] in_data;
   logic                           out_valid;
   logic                           out_ready;
   logic [ecc_pkg::ECC_WORD_W-1:0] out_data;
   logic                           out_last;
   logic                           err_corr;
   logic                           err_uncorr;

   modport slave (
      input  code_in, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, err_corr, err_uncorr
   );

   modport master (
      output code_in, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, err_corr, err_uncorr
   );

endinterface

// File: rtl/ecc_decoder_syndrome_acc.sv
// Per-beat syndrome accumulator. Beat 0 restarts the sum and folds in the check byte,
// so the outputs hold the final syndrome once beat 7 has been accepted.
module ecc_syndrome_acc
   import ecc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_beat_en,
   input  logic [2:0]            i_beat_idx,
   input  logic [ECC_WORD_W-1:0] i_data,
   input  logic [7:0]            i_code,
   output logic [6:0]            o_syn,
   output logic                  o_s7
);

   logic [3:0] w_col;
   logic [2:0] w_row;
   logic [2:0] w_idx_p1;
   logic       w_rowpar;
   logic [6:0] r_syn;
   logic       r_code7;
   logic       r_s7;

   // Contribution of the current beat to column and row syndrome bits.
   always_comb begin
      w_col    = '0;
      w_row    = '0;
      w_rowpar = ^i_data[14:0];
      w_idx_p1 = i_beat_idx + 3'd1;
      for (int k = 0; k < 4; k++) begin
         w_col[k] = ^(i_data[14:0] & ECC_COL_MASK[k]);
      end
      for (int b = 0; b < 3; b++) begin
         w_row[b] = (w_rowpar & i_beat_idx[b])
                  ^ (i_data[15] & (i_beat_idx != 3'd7) & w_idx_p1[b]);
      end
   end

   // Accumulate the syndrome; s7 resolves on the last beat against the latched code[7].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_syn   <= '0;
         r_code7 <= 1'b0;
         r_s7    <= 1'b0;
      end else if (i_beat_en) begin
         if (i_beat_idx == 3'd0) begin
            r_syn   <= {w_row, w_col} ^ i_code[6:0];
            r_code7 <= i_code[7];
            r_s7    <= 1'b0;
         end else begin
            r_syn <= r_syn ^ {w_row, w_col};
         end
         if (i_beat_idx == 3'd7) begin
            r_s7 <= i_data[15] ^ r_code7;
         end
      end
   end

   assign o_syn = r_syn;
   assign o_s7  = r_s7;

endmodule

// File: rtl/ecc_decoder.sv
// Packet ECC check/correct: buffers an 8x16 cell, locates a single data-bit error
// from the accumulated syndrome and replays the corrected words in order.
//
// state   | meaning
// IDLE    | waiting for beat 0 (check byte sampled with it)
// COLLECT | accepting beats 1..7 into the buffer
// DECODE  | syndrome final; registering the error location
// OUT     | presenting words 0..7, flags held until word 7 is taken
module ecc_decoder
   import ecc_pkg::*;
#(
   parameter bit CORRECT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   ecc_decoder_if.slave  bus
);

   ecc_dec_state_t        r_state;
   logic [2:0]            r_beat;
   logic                  r_in_ready;
   logic [ECC_WORD_W-1:0] r_buf [0:ECC_WORDS-1];
   ecc_loc_t              r_loc;
   logic [2:0]            r_word_idx;
   logic                  r_out_valid;
   logic [ECC_WORD_W-1:0] r_out_data;
   logic                  r_out_last;
   logic                  r_err_corr;
   logic                  r_err_uncorr;

   logic                  w_in_acc;
   logic                  w_out_acc;
   logic [6:0]            w_syn;
   logic                  w_s7;
   ecc_loc_t              w_loc;
   logic [2:0]            w_next_idx;
   logic [ECC_WORD_W-1:0] w_next_word;

   assign w_in_acc  = bus.in_valid & r_in_ready;
   assign w_out_acc = r_out_valid & bus.out_ready;
   assign w_loc     = ecc_locate(w_syn, w_s7);

   ecc_syndrome_acc u_syn (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_beat_en  (w_in_acc),
      .i_beat_idx (r_beat),
      .i_data     (bus.in_data),
      .i_code     (bus.code_in),
      .o_syn      (w_syn),
      .o_s7       (w_s7)
   );

   // Buffer fill; contents are don't-care after reset so no reset term.
   always_ff @(posedge clk) begin
      if (w_in_acc) begin
         r_buf[r_beat] <= bus.in_data;
      end
   end

   // Next word to present, with the located bit flipped when correction is enabled.
   always_comb begin
      w_next_idx  = r_out_valid ? (r_word_idx + 3'd1) : r_word_idx;
      w_next_word = r_buf[w_next_idx];
      if (CORRECT_EN && (r_loc.kind == LOC_CORR) && (r_loc.word_idx == w_next_idx)) begin
         w_next_word = w_next_word ^ (16'd1 << r_loc.bit_idx);
      end
   end

   // Control FSM with registered handshake, data and flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_beat       <= 3'd0;
         r_in_ready   <= 1'b1;
         r_loc        <= '0;
         r_word_idx   <= 3'd0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_last   <= 1'b0;
         r_err_corr   <= 1'b0;
         r_err_uncorr <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_in_acc) begin
                  r_beat  <= 3'd1;
                  r_state <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_in_acc) begin
                  r_beat <= r_beat + 3'd1;
                  if (r_beat == 3'd7) begin
                     r_state    <= DECODE;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            DECODE: begin
               r_loc      <= w_loc;
               r_word_idx <= 3'd0;
               r_state    <= OUT;
            end
            OUT: begin
               if (!r_out_valid) begin
                  r_out_valid  <= 1'b1;
                  r_out_data   <= w_next_word;
                  r_out_last   <= (w_next_idx == 3'd7);
                  r_err_corr   <= (r_loc.kind == LOC_CORR);
                  r_err_uncorr <= (r_loc.kind == LOC_UNCORR);
               end else if (w_out_acc) begin
                  if (r_out_last) begin
                     r_out_valid  <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_err_corr   <= 1'b0;
                     r_err_uncorr <= 1'b0;
                     r_in_ready   <= 1'b1;
                     r_state      <= IDLE;
                  end else begin
                     r_word_idx <= w_next_idx;
                     r_out_data <= w_next_word;
                     r_out_last <= (w_next_idx == 3'd7);
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_last   = r_out_last;
   assign bus.err_corr   = r_err_corr;
   assign bus.err_uncorr = r_err_uncorr;

endmodule

// File: tb/tb_ecc_decoder.sv
// Directed bench for ecc_decoder: dut0 corrects, dut1 is detect-only.
// Expected words are queued at stimulus time and checked by per-DUT monitors.
module tb_ecc_decoder;

   typedef logic [7:0][15:0] cell_t;
   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        corr;
      logic        uncorr;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   exp_t q0[$];
   exp_t q1[$];

   ecc_decoder_if bus0();
   ecc_decoder_if bus1();

   ecc_decoder #(.CORRECT_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   ecc_decoder #(.CORRECT_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_cell(input int sel, input cell_t w, input logic corr, input logic uncorr);
      exp_t e;
      for (int j = 0; j < 8; j++) begin
         e.data   = w[j];
         e.last   = (j == 7);
         e.corr   = corr;
         e.uncorr = uncorr;
         if (sel == 0) q0.push_back(e);
         else          q1.push_back(e);
      end
   endtask

   task automatic set_in(input int sel, input logic v, input logic [7:0] code, input logic [15:0] d);
      if (sel == 0) begin
         bus0.in_valid = v; bus0.code_in = code; bus0.in_data = d;
      end else begin
         bus1.in_valid = v; bus1.code_in = code; bus1.in_data = d;
      end
   endtask

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? bus0.in_ready : bus1.in_ready;
   endfunction

   // Drives nbeats beats; returns on the negedge after the last accept edge.
   task automatic send_cell(input int sel, input logic [7:0] code, input cell_t w,
                            input int nbeats, input bit gaps);
      int budget;
      for (int j = 0; j < nbeats; j++) begin
         if (gaps && (j % 3 == 1)) begin
            @(negedge clk);
            set_in(sel, 1'b0, code, 16'hDEAD);
            @(negedge clk);
         end else begin
            @(negedge clk);
         end
         set_in(sel, 1'b1, code, w[j]);
         budget = 0;
         while (!get_ready(sel) && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         if (budget >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout: beat %0d never accepted", j);
            set_in(sel, 1'b0, code, 16'h0000);
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      set_in(sel, 1'b0, code, 16'h0000);
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while ((q0.size() != 0 || q1.size() != 0 || bus0.out_valid || bus1.out_valid) && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      chk("drain_timeout", budget >= 1000, 0);
   endtask

   // Scoreboard monitors: a handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_output", 1, 0);
         end else begin
            e = q0.pop_front();
            chk("dut0_data", {16'h0, bus0.out_data}, {16'h0, e.data});
            chk("dut0_last_corr_uncorr", {29'h0, bus0.out_last, bus0.err_corr, bus0.err_uncorr},
                {29'h0, e.last, e.corr, e.uncorr});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_output", 1, 0);
         end else begin
            e = q1.pop_front();
            chk("dut1_data", {16'h0, bus1.out_data}, {16'h0, e.data});
            chk("dut1_last_corr_uncorr", {29'h0, bus1.out_last, bus1.err_corr, bus1.err_uncorr},
                {29'h0, e.last, e.corr, e.uncorr});
         end
      end
   end

   initial begin
      cell_t c;
      cell_t x;
      logic [15:0] held;
      int budget;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      set_in(0, 1'b0, 8'h00, 16'h0000);
      set_in(1, 1'b0, 8'h00, 16'h0000);
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", {31'h0, bus0.in_ready}, 1);
      chk("reset_outputs", {27'h0, bus0.out_valid, bus0.out_last, bus0.err_corr, bus0.err_uncorr,
          bus1.out_valid}, 0);
      chk("reset_out_data", {16'h0, bus0.out_data}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: all zero, latency 2 edges after the beat-7 accept edge
      c = '0;
      push_cell(0, c, 1'b0, 1'b0);
      send_cell(0, 8'h00, c, 8, 1'b0);
      chk("in_ready_low_after_beat7", {31'h0, bus0.in_ready}, 0);
      @(negedge clk);
      chk("latency_edge1_no_valid", {31'h0, bus0.out_valid}, 0);
      @(negedge clk);
      chk("latency_edge2_valid", {31'h0, bus0.out_valid}, 1);
      wait_drain();

      // 2: clean cell with nonzero data
      c = '0; c[0] = 16'h0001;
      push_cell(0, c, 1'b0, 1'b0);
      send_cell(0, 8'h01, c, 8, 1'b0);
      wait_drain();

      // 3: word3 bit5 flipped -> corrected
      c = '0; c[3] = 16'h0020;
      x = '0;
      push_cell(0, x, 1'b1, 1'b0);
      send_cell(0, 8'h00, c, 8, 1'b0);
      wait_drain();

      // 4a: word2 bit15 flipped -> column 0, row 3
      c = '0; c[2] = 16'h8000;
      push_cell(0, x, 1'b1, 1'b0);
      send_cell(0, 8'h00, c, 8, 1'b0);
      wait_drain();

      // 4b: word7 bit15 flipped -> s7 only
      c = '0; c[7] = 16'h8000;
      push_cell(0, x, 1'b1, 1'b0);
      send_cell(0, 8'h00, c, 8, 1'b0);
      wait_drain();

      // 5a: double error -> uncorrectable, data unchanged
      c = '0; c[7] = 16'h8000; c[0] = 16'h0001;
      push_cell(0, c, 1'b0, 1'b1);
      send_cell(0, 8'h00, c, 8, 1'b0);
      wait_drain();

      // 5b: detect-only instance keeps the bad bit but flags it
      c = '0; c[3] = 16'h0020;
      push_cell(1, c, 1'b1, 1'b0);
      send_cell(1, 8'h00, c, 8, 1'b0);
      wait_drain();

      // Word5 bit14 error over nonzero clean data, with input gaps
      c = '0; c[0] = 16'h0003; c[5] = 16'h4000;
      x = '0; x[0] = 16'h0003;
      push_cell(0, x, 1'b1, 1'b0);
      send_cell(0, 8'h03, c, 8, 1'b1);
      wait_drain();

      // 6: output back-pressure mid-stream
      c = '0; c[0] = 16'h0001; c[4] = 16'h1234 ^ 16'h1234;
      push_cell(0, c, 1'b0, 1'b0);
      send_cell(0, 8'h01, c, 8, 1'b0);
      budget = 0;
      while (!bus0.out_valid && budget < 100) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("stall_wait_timeout", budget >= 100, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus0.out_ready = 1'b0;
      held = bus0.out_data;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid_held", {31'h0, bus0.out_valid}, 1);
         chk("stall_data_held", {16'h0, bus0.out_data}, {16'h0, held});
      end
      @(posedge clk); #1;
      bus0.out_ready = 1'b1;
      wait_drain();

      // Reset after beat 4 aborts the cell with no output
      c = '0; c[1] = 16'hAAAA;
      send_cell(0, 8'h5A, c, 5, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", {31'h0, bus0.in_ready}, 1);
      chk("abort_out_valid", {31'h0, bus0.out_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_output", {31'h0, bus0.out_valid}, 0);

      // Full clean cell after the abort
      for (int j = 0; j < 8; j++) c[j] = 16'hFFFF;
      push_cell(0, c, 1'b0, 1'b0);
      send_cell(0, 8'h80, c, 8, 1'b0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
